// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and NOP-run halt detection
//
// Purpose: fetches little-endian 32-bit words from a byte-addressed instruction
// memory, registers them into the IF/ID pipeline register, honours stall and
// branch redirect, and halts after HALT_NOPS consecutive valid all-zero fetches.
//
// Ports:
//   clk               in   rising-edge clock
//   reset             in   asynchronous active-high reset
//   instruction_mem   in   [7:0] x IMEM_BYTES byte array
//   stall             in   hold pc and IF/ID (load-use hazard)
//   branch_taken      in   redirect request from execute
//   branch_target     in   [31:0] redirect byte address (word-aligned on use)
//   pc                out  [31:0] current fetch address
//   if_id_instruction out  [31:0] registered instruction word
//   if_id_pc_plus4    out  [31:0] registered fetch address + 4
//   if_id_valid       out  registered: 1 = real fetch, 0 = bubble
//   halt              out  registered, sticky until reset

module fetch_stage #(
  parameter int IMEM_BYTES = 256,
  parameter int HALT_NOPS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instruction_mem [IMEM_BYTES],
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halt
);

  localparam int         AW       = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [2:0] HALT_CNT = 3'(HALT_NOPS);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [2:0]  r_nop_cnt;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_pc_plus4_next;
  logic        w_valid_next;
  logic [2:0]  w_nop_cnt_next;

  logic [32:0]   w_last_byte;
  logic          w_in_range;
  logic [AW-1:0] w_idx0;
  logic [AW-1:0] w_idx1;
  logic [AW-1:0] w_idx2;
  logic [AW-1:0] w_idx3;
  logic [31:0]   w_fetch_word;
  logic [31:0]   w_pc_plus4;
  logic [2:0]    w_cnt_adv;

  // 33-bit add so a pc near 2^32 cannot wrap back into range.
  assign w_last_byte = {1'b0, r_pc} + 33'd3;
  assign w_in_range  = (w_last_byte < 33'(IMEM_BYTES));
  assign w_idx0      = r_pc[AW-1:0];
  assign w_idx1      = w_idx0 + AW'(1);
  assign w_idx2      = w_idx0 + AW'(2);
  assign w_idx3      = w_idx0 + AW'(3);
  assign w_pc_plus4  = r_pc + 32'd4;

  // Indices are only consumed when the whole word lies inside the array.
  always_comb begin
    w_fetch_word = 32'h0;
    if (w_in_range) begin
      w_fetch_word = {instruction_mem[w_idx3], instruction_mem[w_idx2],
                      instruction_mem[w_idx1], instruction_mem[w_idx0]};
    end
  end

  // Run-length of zero words, saturating at the halt threshold.
  always_comb begin
    w_cnt_adv = 3'd0;
    if (w_fetch_word == 32'h0) begin
      w_cnt_adv = (r_nop_cnt >= HALT_CNT) ? r_nop_cnt : r_nop_cnt + 3'd1;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_pc_plus4_next = r_pc_plus4;
    w_valid_next    = r_valid;
    w_nop_cnt_next  = r_nop_cnt;
    case (r_state)
      S_RUN: begin
        if (branch_taken) begin
          // Flush wins over stall; low address bits are forced to word alignment.
          w_pc_next       = branch_target & ~32'h3;
          w_instr_next    = 32'h0;
          w_pc_plus4_next = 32'h0;
          w_valid_next    = 1'b0;
        end else if (!stall) begin
          w_pc_next       = w_pc_plus4;
          w_instr_next    = w_fetch_word;
          w_pc_plus4_next = w_pc_plus4;
          w_valid_next    = 1'b1;
          w_nop_cnt_next  = w_cnt_adv;
          if (w_cnt_adv == HALT_CNT) begin
            // Halting edge: pc still advances, but decode sees a bubble.
            w_state_next = S_HALTED;
            w_instr_next = 32'h0;
            w_valid_next = 1'b0;
          end
        end
      end
      S_HALTED: begin
        w_instr_next = 32'h0;
        w_valid_next = 1'b0;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_pc       <= 32'h0;
      r_instr    <= 32'h0;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
      r_nop_cnt  <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_pc_plus4 <= w_pc_plus4_next;
      r_valid    <= w_valid_next;
      r_nop_cnt  <= w_nop_cnt_next;
    end
  end

  assign pc                = r_pc;
  assign if_id_instruction = r_instr;
  assign if_id_pc_plus4    = r_pc_plus4;
  assign if_id_valid       = r_valid;
  assign halt              = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [7:0]  mem [256];
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halt;

  int checks;
  int failures;

  logic [97:0] obs;
  logic [65:0] obs_h;
  assign obs   = {pc, if_id_instruction, if_id_pc_plus4, if_id_valid, halt};
  assign obs_h = {pc, if_id_instruction, if_id_valid, halt};

  fetch_stage #(.IMEM_BYTES(256), .HALT_NOPS(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .instruction_mem   (mem),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .pc                (pc),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .halt              (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] b);
    for (int i = 0; i < 256; i++) mem[i] = b;
  endtask

  task automatic set_word(input int a, input logic [31:0] w);
    mem[a]   = w[7:0];
    mem[a+1] = w[15:8];
    mem[a+2] = w[23:16];
    mem[a+3] = w[31:24];
  endtask

  task automatic test_reset();
    #1;
    if (obs !== 98'h0) begin
      failures++; $display("FAIL reset_state got=%h want=%h", obs, 98'h0);
    end
    checks++;
  endtask

  task automatic test_basic_fetch();
    fill_mem(8'h00);
    set_word(0, 32'h200a000a);
    do_reset();
    step();
    if (obs !== {32'h4, 32'h200a000a, 32'h4, 1'b1, 1'b0}) begin
      failures++; $display("FAIL basic_fetch got=%h want=%h", obs, {32'h4, 32'h200a000a, 32'h4, 1'b1, 1'b0});
    end
    checks++;
  endtask

  task automatic test_stall();
    fill_mem(8'h00);
    for (int i = 0; i < 16; i++) set_word(4 * i, 32'h1000_0000 + 32'(i));
    do_reset();
    step();
    step();
    if (obs !== {32'd8, 32'h10000001, 32'd8, 1'b1, 1'b0}) begin
      failures++; $display("FAIL stall_setup got=%h want=%h", obs, {32'd8, 32'h10000001, 32'd8, 1'b1, 1'b0});
    end
    checks++;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (obs !== {32'd8, 32'h10000001, 32'd8, 1'b1, 1'b0}) begin
        failures++; $display("FAIL stall_hold_%0d got=%h want=%h", k, obs, {32'd8, 32'h10000001, 32'd8, 1'b1, 1'b0});
      end
      checks++;
    end
    stall = 1'b0;
    step();
    if (obs !== {32'd12, 32'h10000002, 32'd12, 1'b1, 1'b0}) begin
      failures++; $display("FAIL stall_release got=%h want=%h", obs, {32'd12, 32'h10000002, 32'd12, 1'b1, 1'b0});
    end
    checks++;
  endtask

  task automatic test_branch_over_stall();
    fill_mem(8'h00);
    for (int i = 3; i < 8; i++) set_word(4 * i, 32'h3333_3333);
    for (int i = 9; i < 13; i++) set_word(4 * i, 32'h4444_4444);
    do_reset();
    step(); step(); step();
    if (obs !== {32'd12, 32'h0, 32'd12, 1'b1, 1'b0}) begin
      failures++; $display("FAIL branch_pre got=%h want=%h", obs, {32'd12, 32'h0, 32'd12, 1'b1, 1'b0});
    end
    checks++;
    branch_taken = 1'b1;
    branch_target = 32'h23;
    stall = 1'b1;
    step();
    if (obs !== {32'h20, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL branch_flush got=%h want=%h", obs, {32'h20, 32'h0, 32'h0, 1'b0, 1'b0});
    end
    checks++;
    branch_taken = 1'b0;
    stall = 1'b0;
    step();
    if (obs_h !== {32'h24, 32'h0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL branch_count_kept got=%h want=%h", obs_h, {32'h24, 32'h0, 1'b0, 1'b1});
    end
    checks++;
  endtask

  task automatic test_halt();
    fill_mem(8'h00);
    set_word(0, 32'h1111_1111);
    set_word(4, 32'h2222_2222);
    do_reset();
    step();
    if (obs !== {32'd4, 32'h11111111, 32'd4, 1'b1, 1'b0}) begin
      failures++; $display("FAIL halt_w0 got=%h want=%h", obs, {32'd4, 32'h11111111, 32'd4, 1'b1, 1'b0});
    end
    checks++;
    step();
    step(); step(); step();
    if (obs !== {32'd20, 32'h0, 32'd20, 1'b1, 1'b0}) begin
      failures++; $display("FAIL halt_third_zero got=%h want=%h", obs, {32'd20, 32'h0, 32'd20, 1'b1, 1'b0});
    end
    checks++;
    step();
    if (obs_h !== {32'd24, 32'h0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL halt_fourth_zero got=%h want=%h", obs_h, {32'd24, 32'h0, 1'b0, 1'b1});
    end
    checks++;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (obs_h !== {32'd24, 32'h0, 1'b0, 1'b1}) begin
        failures++; $display("FAIL halt_frozen_%0d got=%h want=%h", k, obs_h, {32'd24, 32'h0, 1'b0, 1'b1});
      end
      checks++;
    end
    branch_taken = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_count_clear();
    fill_mem(8'h00);
    set_word(12, 32'hABCD_0003);
    do_reset();
    step(); step(); step(); step();
    if (obs !== {32'd16, 32'hABCD0003, 32'd16, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clear_nonzero got=%h want=%h", obs, {32'd16, 32'hABCD0003, 32'd16, 1'b1, 1'b0});
    end
    checks++;
    step(); step(); step();
    if (obs !== {32'd28, 32'h0, 32'd28, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clear_no_halt got=%h want=%h", obs, {32'd28, 32'h0, 32'd28, 1'b1, 1'b0});
    end
    checks++;
    step();
    if (obs_h !== {32'd32, 32'h0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL clear_then_halt got=%h want=%h", obs_h, {32'd32, 32'h0, 1'b0, 1'b1});
    end
    checks++;
  endtask

  task automatic test_boundary();
    fill_mem(8'h5A);
    mem[252] = 8'h11; mem[253] = 8'h22; mem[254] = 8'h33; mem[255] = 8'h44;
    do_reset();
    branch_taken = 1'b1;
    branch_target = 32'hFC;
    step();
    if (obs !== {32'hFC, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL bound_redirect got=%h want=%h", obs, {32'hFC, 32'h0, 32'h0, 1'b0, 1'b0});
    end
    checks++;
    branch_taken = 1'b0;
    step();
    if (obs !== {32'h100, 32'h44332211, 32'h100, 1'b1, 1'b0}) begin
      failures++; $display("FAIL bound_last_word got=%h want=%h", obs, {32'h100, 32'h44332211, 32'h100, 1'b1, 1'b0});
    end
    checks++;
    step();
    if (obs !== {32'h104, 32'h0, 32'h104, 1'b1, 1'b0}) begin
      failures++; $display("FAIL bound_oob_zero got=%h want=%h", obs, {32'h104, 32'h0, 32'h104, 1'b1, 1'b0});
    end
    checks++;
    step(); step(); step();
    if (obs_h !== {32'h110, 32'h0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL bound_oob_halt got=%h want=%h", obs_h, {32'h110, 32'h0, 1'b0, 1'b1});
    end
    checks++;
  endtask

  task automatic test_async_reset_halted();
    #3;
    reset = 1'b1;
    #1;
    if (obs !== 98'h0) begin
      failures++; $display("FAIL async_reset got=%h want=%h", obs, 98'h0);
    end
    checks++;
    #1;
    reset = 1'b0;
    step();
    if (obs !== {32'd4, 32'h5A5A5A5A, 32'd4, 1'b1, 1'b0}) begin
      failures++; $display("FAIL async_resume got=%h want=%h", obs, {32'd4, 32'h5A5A5A5A, 32'd4, 1'b1, 1'b0});
    end
    checks++;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_branch_over_stall();
    test_halt();
    test_count_clear();
    test_boundary();
    test_async_reset_halted();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter IMEM_BYTES, default 256: size of the byte-addressed instruction memory port.
REQ-002 Parameter HALT_NOPS, default 4: consecutive valid all-zero fetches that trigger halt.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instruction_mem  input  8 x IMEM_BYTES  unpacked byte array, index 0..IMEM_BYTES-1.
REQ-006 stall  input  1  hold PC and IF/ID register (load-use hazard from decode).
REQ-007 branch_taken  input  1  redirect request from execute stage.
REQ-008 branch_target  input  32  redirect byte address.
REQ-009 pc  output  32  current fetch address.
REQ-010 if_id_instruction  output  32  registered instruction word to decode.
REQ-011 if_id_pc_plus4  output  32  registered fetch address + 4.
REQ-012 if_id_valid  output  1  registered: 1 = real fetch, 0 = bubble.
REQ-013 halt  output  1  registered: program ended; sticky until reset.

Function
REQ-014 The fetch word SHALL be little-endian: {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}.
REQ-015 If pc+3 >= IMEM_BYTES, the fetch word SHALL be 32'h0 (no out-of-range array access).
REQ-016 Per-edge priority SHALL be: halt > branch_taken > stall > normal advance.
REQ-017 Normal advance: IF/ID <= {fetch word, pc+4, valid=1}; pc <= pc+4 (32-bit wrap).
REQ-018 branch_taken=1: pc <= {branch_target[31:2], 2'b00}; IF/ID <= {32'h0, 32'h0, valid=0} (flush), even if stall=1.
REQ-019 stall=1 with branch_taken=0: pc, IF/ID, and NOP counter SHALL hold.
REQ-020 Fetch latency SHALL be one cycle: the word at pc appears on if_id_instruction after the next rising edge.
REQ-021 NOP counter (3-bit, saturating at HALT_NOPS): increments when a valid fetch of 32'h0 is latched; clears when a valid nonzero word is latched; unchanged on flush and stall.
REQ-022 halt SHALL assert on the edge the counter reaches HALT_NOPS and remain 1 until reset.
REQ-023 While halt=1: pc frozen; if_id_instruction=0, if_id_valid=0; stall and branch_taken ignored.
REQ-024 Out-of-range fetches (REQ-015) SHALL count as zero words toward halt.
REQ-025 State machine: RUN (advance/stall/flush per REQ-016..019) -> HALTED when counter == HALT_NOPS; HALTED -> RUN only via reset.

Reset
REQ-026 On reset=1, immediately and regardless of clk: pc=0, if_id_instruction=0, if_id_pc_plus4=0, if_id_valid=0, NOP counter=0, halt=0, state=RUN.
REQ-027 Reset asserted mid-stall, mid-branch, or while HALTED SHALL give the same values; the first fetch after deassertion is address 0.

Verification
REQ-028 mem[3:0]=20,0a,00,0a (idx3..0), reset release, 1 edge -> if_id_instruction=32'h200a000a, if_id_pc_plus4=4, valid=1, pc=4.
REQ-029 Free run, stall=1 at pc=8 for 3 edges -> pc stays 8, IF/ID unchanged; release -> pc=12 next edge.
REQ-030 branch_taken=1 with branch_target=32'h23 and stall=1 -> next edge pc=32'h20, if_id_valid=0, if_id_instruction=0; NOP counter unchanged.
REQ-031 Program: 2 nonzero words then zeros -> halt=1 exactly on the 4th consecutive zero fetch (pc=24 at halt), pc frozen thereafter; 3 zeros then nonzero word -> no halt, counter cleared.
REQ-032 branch_target=32'hFC with IMEM_BYTES=256 -> fetch at 0xFC is in range (bytes 252..255); next pc=0x100 fetches 0 and counts toward halt.
REQ-033 Assert reset asynchronously between edges while halt=1 -> all outputs zero at once; after release, fetch resumes at pc=0.
